bmc_encoder: RTL and testbench
==============================

// Module: bmc_encoder
// PURPOSE
//  Biphase-mark (BMC) transmitter for the tracker link. It serialises one DATA_WIDTH word per frame onto bmc_out, MSB first.
//  Bit cell timing matches the 96 MHz BMC receiver path, so the output loops back cleanly into that decoder in the test bench.
//  Sits between the frame/packet logic (valid/ready source) and the optical/LED driver or a loopback pin.
// PARAMETERS
//  DATA_WIDTH     17  bits per frame, sent MSB first
//  HALF_BIT_TICKS 8   clk cycles per half bit cell (full cell = 2*HALF_BIT_TICKS = 16 = 6 Mbit/s)
//  GUARD_TICKS    32  quiet cycles after closing edge; must exceed receiver timeout (24) so it resyncs
//  PREAMBLE_BITS  2   '0' cells sent before data when BMC_PREAMBLE_EN defined
// PORTS
//  clk_96MHz  in   1           system clock
//  reset      in   1           synchronous, active-high
//  enabled    in   1           allows new frames to be accepted
//  sys_ts     in   24          free-running system timestamp
//  tx_data    in   DATA_WIDTH  frame payload
//  tx_valid   in   1           payload valid
//  tx_ready   out  1           encoder can accept (comb. from state & enabled)
//  bmc_out    out  1           BMC line
//  busy       out  1           frame in flight (PREAMBLE/DATA/STOP)
//  tx_done    out  1           1-cycle pulse when GUARD ends
//  ts_last_tx out  24          sys_ts captured at accept
// BEHAVIOUR
//  Reset: bmc_out=0, busy=0, tx_done=0, ts_last_tx=0, state=IDLE, all counters 0; a frame in flight is abandoned.
//  Reset also drops tx_ready in the reset cycle. bmc_out is not toggled by reset except forcing it to 0.
//  Handshake: accept when tx_valid && tx_ready. tx_ready = (state==IDLE) && enabled.
//  On accept, latch tx_data into the shift register and sys_ts into ts_last_tx. busy=1 from the next cycle.
//  Encoding: each cell begins with a bmc_out toggle. A '1' toggles again at HALF_BIT_TICKS into the cell; a '0' does not.
//  Latency: accept on edge T -> first toggle visible after edge T+1. Cell k starts at T+1+k*2*HALF_BIT_TICKS.
//  FSM IDLE -> (accept) PREAMBLE -> DATA -> STOP -> IDLE. PREAMBLE is skipped without the macro.
//  DATA: tick counter 0..2*HALF_BIT_TICKS-1. Bit counter DATA_WIDTH-1 down to 0, shifting left; the MSB is the current bit.
//  STOP: toggle once at what would be the next cell start (the closing edge bounds the last cell's width).
//   Then hold the line for GUARD_TICKS cycles, pulse tx_done, and return to IDLE.
//  Min frame-to-frame: the next accept is possible the cycle after tx_done. No overlap or queueing (single-entry).
//  tx_data/tx_valid are ignored while busy. tx_valid dropping mid-frame has no effect.
//  enabled is sampled only in IDLE. Deasserting it mid-frame lets the frame complete.
//  bmc_out idle level = whatever the last toggle left; the polarity is irrelevant to BMC.
//  Counters are sized $clog2 of their max+1 and never wrap. DATA_WIDTH=1 is legal (one cell + closing edge).
//  tx_done and accept can't coincide (tx_ready=0 during STOP).
// CONFIGURATION
//  BMC_PREAMBLE_EN defined: PREAMBLE_BITS '0' cells precede data (one toggle per 16 ticks), letting the receiver lock before payload.
//   ts_last_tx is still captured at accept.
//  BMC_PREAMBLE_EN undefined: data cells follow accept directly. The PREAMBLE state and its counter are not built.
// TESTING
//  1 reset, DATA_WIDTH=17, tx_data=17'h1FFFF -> 35 toggles spaced 8 cycles; tx_done 32 cycles after last toggle; busy low next cycle
//  2 tx_data=17'h00000 -> 18 toggles spaced 16 cycles (17 cells + closing edge); no mid-cell toggles
//  3 tx_data=17'h15555, sys_ts=24'hABCDEF at accept -> toggle pattern decodes to 15555; ts_last_tx=ABCDEF; loopback into receiver gives decoded_data=17'h15555
//  4 tx_valid held high with 2 words back-to-back -> second accepted exactly 1 cycle after tx_done; tx_ready=0 throughout frame 1
//  5 reset asserted at cell 9 of a frame -> next cycle bmc_out=0, busy=0, tx_ready=enabled; no further toggles until new accept
//  6 BMC_PREAMBLE_EN, PREAMBLE_BITS=2, tx_data=17'h1FFFF -> first two cells have one toggle at 16-cycle spacing, then 34 fast toggles

Source files
------------

// File: rtl/bmc_encoder_if.sv
// Transmit handshake between the frame/packet source and the BMC encoder.
interface bmc_encoder_if #(
  parameter int DATA_WIDTH = 17
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/bmc_encoder.sv
// Biphase-mark transmitter: one DATA_WIDTH word per frame, MSB first, then a closing edge and a guard gap.
// Optional BMC_PREAMBLE_EN prepends PREAMBLE_BITS '0' cells so the receiver can lock before the payload.
module bmc_encoder #(
  parameter int DATA_WIDTH     = 17,
  parameter int HALF_BIT_TICKS = 8,
  parameter int GUARD_TICKS    = 32
`ifdef BMC_PREAMBLE_EN
  , parameter int PREAMBLE_BITS = 2
`endif
) (
  input  logic         clk_96MHz,
  input  logic         reset,
  input  logic         enabled,
  input  logic [23:0]  sys_ts,
  bmc_encoder_if.slave tx,
  output logic         bmc_out,
  output logic         busy,
  output logic         tx_done,
  output logic [23:0]  ts_last_tx
);
  localparam int CELL_TICKS = 2 * HALF_BIT_TICKS;
  localparam int TICK_W     = (CELL_TICKS > 1) ? $clog2(CELL_TICKS) : 1;
  localparam int BIT_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int GUARD_W    = $clog2(GUARD_TICKS + 1);
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(CELL_TICKS - 1);
  localparam logic [TICK_W-1:0]  TICK_MID   = TICK_W'(HALF_BIT_TICKS);
  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(DATA_WIDTH - 1);
  localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_TICKS);

`ifdef BMC_PREAMBLE_EN
  localparam int PRE_W = (PREAMBLE_BITS > 1) ? $clog2(PREAMBLE_BITS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_BITS - 1);
  typedef enum logic [1:0] {IDLE = 2'd0, PREAMBLE = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;
  logic [PRE_W-1:0] pre_r, pre_s;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd2, STOP = 2'd3} state_t;
`endif

  state_t                state_r, state_s;
  logic [TICK_W-1:0]     tick_r, tick_s;
  logic [BIT_W-1:0]      bit_r, bit_s;
  logic [GUARD_W-1:0]    guard_r, guard_s;
  logic [DATA_WIDTH-1:0] shift_r, shift_s;
  logic                  bmc_s, busy_s, done_s;
  logic [23:0]           ts_s;
  logic                  accept_s;

  assign tx.tx_ready = (state_r == IDLE) && enabled && !reset;
  assign accept_s    = tx.tx_valid && tx.tx_ready;

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_s = state_r;
    tick_s  = tick_r;
    bit_s   = bit_r;
    guard_s = guard_r;
    shift_s = shift_r;
    bmc_s   = bmc_out;
    busy_s  = busy;
    done_s  = 1'b0;
    ts_s    = ts_last_tx;
`ifdef BMC_PREAMBLE_EN
    pre_s   = pre_r;
`endif
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          shift_s = tx.tx_data;
          ts_s    = sys_ts;
          busy_s  = 1'b1;
          tick_s  = {TICK_W{1'b0}};
          bit_s   = BIT_LAST;
          guard_s = {GUARD_W{1'b0}};
`ifdef BMC_PREAMBLE_EN
          pre_s   = PRE_LAST;
          state_s = PREAMBLE;
`else
          state_s = DATA;
`endif
        end else begin
          busy_s = 1'b0;
        end
      end
`ifdef BMC_PREAMBLE_EN
      // Preamble cells are plain '0' cells: a single edge at cell start.
      PREAMBLE: begin
        if (tick_r == {TICK_W{1'b0}}) begin
          bmc_s = ~bmc_out;
        end else begin
          bmc_s = bmc_out;
        end
        if (tick_r == TICK_LAST) begin
          tick_s = {TICK_W{1'b0}};
          if (pre_r == {PRE_W{1'b0}}) begin
            state_s = DATA;
          end else begin
            pre_s = pre_r - {{(PRE_W-1){1'b0}}, 1'b1};
          end
        end else begin
          tick_s = tick_r + {{(TICK_W-1){1'b0}}, 1'b1};
        end
      end
`endif
      DATA: begin
        if (tick_r == {TICK_W{1'b0}}) begin
          bmc_s = ~bmc_out;
        end else if ((tick_r == TICK_MID) && shift_r[DATA_WIDTH-1]) begin
          bmc_s = ~bmc_out;
        end else begin
          bmc_s = bmc_out;
        end
        if (tick_r == TICK_LAST) begin
          tick_s  = {TICK_W{1'b0}};
          shift_s = shift_r << 1'b1;
          if (bit_r == {BIT_W{1'b0}}) begin
            state_s = STOP;
            guard_s = {GUARD_W{1'b0}};
          end else begin
            bit_s = bit_r - {{(BIT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          tick_s = tick_r + {{(TICK_W-1){1'b0}}, 1'b1};
        end
      end
      // Closing edge first, then the guard gap; tx_done is raised while still in STOP
      // so it can never coincide with an accept.
      STOP: begin
        if (tx_done) begin
          state_s = IDLE;
          busy_s  = 1'b0;
        end else if (guard_r == {GUARD_W{1'b0}}) begin
          bmc_s   = ~bmc_out;
          guard_s = {{(GUARD_W-1){1'b0}}, 1'b1};
        end else if (guard_r == GUARD_LAST) begin
          done_s = 1'b1;
        end else begin
          guard_s = guard_r + {{(GUARD_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk_96MHz) begin
    if (reset) begin
      state_r    <= IDLE;
      tick_r     <= {TICK_W{1'b0}};
      bit_r      <= {BIT_W{1'b0}};
      guard_r    <= {GUARD_W{1'b0}};
      shift_r    <= {DATA_WIDTH{1'b0}};
      bmc_out    <= 1'b0;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
      ts_last_tx <= 24'h000000;
`ifdef BMC_PREAMBLE_EN
      pre_r      <= {PRE_W{1'b0}};
`endif
    end else begin
      state_r    <= state_s;
      tick_r     <= tick_s;
      bit_r      <= bit_s;
      guard_r    <= guard_s;
      shift_r    <= shift_s;
      bmc_out    <= bmc_s;
      busy       <= busy_s;
      tx_done    <= done_s;
      ts_last_tx <= ts_s;
`ifdef BMC_PREAMBLE_EN
      pre_r      <= pre_s;
`endif
    end
  end
endmodule

// File: tb/tb_bmc_encoder.sv
// Self-checking bench for bmc_encoder: cell-level reference model of the BMC line, handshake and reset checks.
// Honours BMC_PREAMBLE_EN when the design is built with it.
module tb_bmc_encoder;
  localparam int DW    = 17;
  localparam int HALF  = 8;
  localparam int CELL  = 2 * HALF;
  localparam int GUARD = 32;
`ifdef BMC_PREAMBLE_EN
  localparam int NPRE = 2;
`else
  localparam int NPRE = 0;
`endif

  logic        clk_96MHz = 1'b0;
  logic        reset;
  logic        enabled;
  logic [23:0] sys_ts;
  logic        bmc_out, busy, tx_done;
  logic [23:0] ts_last_tx;
  int          checks   = 0;
  int          failures = 0;
  logic        cur_lvl  = 1'b0;

  bmc_encoder_if #(.DATA_WIDTH(DW)) tx_if ();

  bmc_encoder dut (
    .clk_96MHz (clk_96MHz),
    .reset     (reset),
    .enabled   (enabled),
    .sys_ts    (sys_ts),
    .tx        (tx_if),
    .bmc_out   (bmc_out),
    .busy      (busy),
    .tx_done   (tx_done),
    .ts_last_tx(ts_last_tx)
  );

  always #5 clk_96MHz = ~clk_96MHz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_96MHz); #1;
      chk("idle_bmc_out", bmc_out, cur_lvl);
      chk("idle_busy", busy, 1'b0);
    end
  endtask

  // One frame: expected line built from the cell list (start edge per cell, extra mid edge for '1').
  task automatic send_frame(input logic [DW-1:0] d, input logic [23:0] ts,
                            input bit hold_valid, input int abort_at, input bit drop_en);
    bit           cells[$];
    bit           tog[];
    logic         obs[];
    logic         lvl;
    logic [DW-1:0] dec;
    int           ncells, close_off, last_off, off;
    cells = {};
    for (int k = 0; k < NPRE; k++) cells.push_back(1'b0);
    for (int k = DW - 1; k >= 0; k--) cells.push_back(d[k]);
    ncells    = cells.size();
    close_off = 1 + CELL * ncells;
    last_off  = close_off + GUARD + 1;
    tog = new[last_off + 1];
    obs = new[last_off + 1];
    foreach (tog[i]) tog[i] = 1'b0;
    for (int k = 0; k < ncells; k++) begin
      tog[1 + CELL * k] = 1'b1;
      if (cells[k]) tog[1 + CELL * k + HALF] = 1'b1;
    end
    tog[close_off] = 1'b1;

    tx_if.tx_data  = d;
    tx_if.tx_valid = 1'b1;
    sys_ts         = ts;
    #1;
    chk("ready_before_accept", tx_if.tx_ready, enabled);
    @(posedge clk_96MHz); #1;
    lvl = cur_lvl;
    if (!hold_valid) tx_if.tx_valid = 1'b0;
    tx_if.tx_data = DW'($urandom);
    sys_ts        = 24'($urandom);
    if (drop_en) enabled = 1'b0;
    for (int n = 0; n <= last_off; n++) begin
      if (n > 0) begin
        @(posedge clk_96MHz); #1;
      end
      lvl    = lvl ^ tog[n];
      obs[n] = bmc_out;
      chk("bmc_out", bmc_out, lvl);
      chk("busy", busy, (n <= close_off + GUARD));
      chk("tx_done", tx_done, (n == close_off + GUARD));
      chk("tx_ready", tx_if.tx_ready, (n > close_off + GUARD) ? enabled : 1'b0);
      if (n == 0) chk("ts_last_tx", ts_last_tx, ts);
      if (n == abort_at) begin
        reset = 1'b1;
        #1;
        chk("ready_in_reset", tx_if.tx_ready, 1'b0);
        @(posedge clk_96MHz); #1;
        chk("rst_bmc_out", bmc_out, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tx_done", tx_done, 1'b0);
        chk("rst_ts", ts_last_tx, 24'h000000);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", tx_if.tx_ready, enabled);
        cur_lvl = 1'b0;
        idle_cycles(40);
        return;
      end
    end
    cur_lvl = lvl;
    // Independent decode of the captured line: a data bit is 1 when the line flips mid-cell.
    dec = '0;
    for (int k = 0; k < DW; k++) begin
      off = 1 + CELL * (NPRE + k);
      dec[DW - 1 - k] = obs[off + HALF] ^ obs[off + HALF - 1];
    end
    chk("decoded_data", dec, d);
  endtask

  initial begin
    reset          = 1'b1;
    enabled        = 1'b1;
    sys_ts         = 24'h000000;
    tx_if.tx_data  = '0;
    tx_if.tx_valid = 1'b0;
    repeat (3) @(posedge clk_96MHz);
    #1;
    chk("reset_bmc_out", bmc_out, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_tx_done", tx_done, 1'b0);
    chk("reset_ts", ts_last_tx, 24'h000000);
    chk("reset_ready", tx_if.tx_ready, 1'b0);
    reset = 1'b0;
    #1;
    chk("ready_out_of_reset", tx_if.tx_ready, 1'b1);
    cur_lvl = 1'b0;

    // All-ones, all-zeros and alternating patterns.
    send_frame(17'h1FFFF, 24'h123456, 1'b0, -1, 1'b0);
    idle_cycles(3);
    send_frame(17'h00000, 24'h000001, 1'b0, -1, 1'b0);
    idle_cycles(3);
    send_frame(17'h15555, 24'hABCDEF, 1'b0, -1, 1'b0);
    idle_cycles(2);

    // Back-to-back with tx_valid held high.
    send_frame(DW'($urandom), 24'($urandom), 1'b1, -1, 1'b0);
    send_frame(DW'($urandom), 24'($urandom), 1'b0, -1, 1'b0);
    idle_cycles(2);

    // Disabled encoder refuses frames.
    enabled        = 1'b0;
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = 17'h0F0F0;
    #1;
    chk("ready_disabled", tx_if.tx_ready, 1'b0);
    idle_cycles(10);
    tx_if.tx_valid = 1'b0;
    enabled        = 1'b1;

    // Dropping enabled mid-frame lets the frame finish.
    send_frame(DW'($urandom), 24'($urandom), 1'b0, -1, 1'b1);
    enabled = 1'b1;
    idle_cycles(2);

    for (int i = 0; i < 4; i++) begin
      send_frame(DW'($urandom), 24'($urandom), 1'b0, -1, 1'b0);
      idle_cycles(int'($urandom_range(0, 5)));
    end

    // Reset during data cell 9, then recovery.
    send_frame(DW'($urandom), 24'($urandom), 1'b0, 1 + CELL * (NPRE + 9) + 3, 1'b0);
    send_frame(DW'($urandom), 24'($urandom), 1'b0, -1, 1'b0);
    idle_cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
